apb_master: RTL and testbench

APB initiator that converts single commands from an on-chip host (CPU bridge, test sequencer) into APB3 transfers toward APB responders such as the register-file slave. It accepts one command at a time over a valid/ready handshake, sequences SETUP and ACCESS phases, and honours responder wait states (PREADY). It returns read data and error status as a one-cycle response pulse. A programmable watchdog aborts transfers whose responder never asserts PREADY.

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_master_if.sv | 26 ++
 rtl/apb_master.sv | 118 +++++++++++
 tb/tb_apb_master.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB initiator slice.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// APB3 bus bundle between one initiator and its responders.
interface apb_master_if import apb_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = APB_ADDR_W,
  parameter int unsigned DATA_WIDTH = APB_DATA_W
);

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_master.sv
// APB3 initiator: one host command at a time through SETUP/ACCESS, with a
// PREADY watchdog that aborts hung transfers and a one-cycle response pulse.
module apb_master import apb_pkg::*; #(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_W,
  parameter int unsigned DATA_WIDTH     = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  apb_master_if.master          apb
);

  // Counter keeps at least one bit so a disabled watchdog still elaborates.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               WDOG_EN   = (TIMEOUT_CYCLES != 0);

  apb_state_e            state, state_nxt;
  logic [CNT_W-1:0]      wd_cnt, wd_cnt_nxt;
  logic                  psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic [DATA_WIDTH-1:0] pwdata_nxt;
  logic                  rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_nxt;

  assign cmd_ready = (state == APB_IDLE);

  // Next-state, bus and response decode.
  always_comb begin
    state_nxt       = state;
    wd_cnt_nxt      = wd_cnt;
    pwrite_nxt      = apb.PWRITE;
    paddr_nxt       = apb.PADDR;
    pwdata_nxt      = apb.PWDATA;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = '0;
    rsp_err_nxt     = 1'b0;
    rsp_timeout_nxt = 1'b0;

    case (state)
      APB_IDLE: begin
        if (cmd_valid) begin
          state_nxt  = APB_SETUP;
          pwrite_nxt = cmd_write;
          paddr_nxt  = cmd_addr;
          pwdata_nxt = cmd_wdata;
        end
      end

      APB_SETUP: begin
        state_nxt  = APB_ACCESS;
        wd_cnt_nxt = '0;
      end

      APB_ACCESS: begin
        if (apb.PREADY) begin
          state_nxt     = APB_IDLE;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = apb.PWRITE ? '0 : apb.PRDATA;
          rsp_err_nxt   = apb.PSLVERR;
        end else begin
          wd_cnt_nxt = (wd_cnt == CNT_MAX) ? wd_cnt : wd_cnt + CNT_W'(1);
          if (WDOG_EN && (wd_cnt_nxt == CNT_LIMIT)) begin
            state_nxt       = APB_IDLE;
            rsp_valid_nxt   = 1'b1;
            rsp_err_nxt     = 1'b1;
            rsp_timeout_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = APB_IDLE;
    endcase

    psel_nxt    = (state_nxt != APB_IDLE);
    penable_nxt = (state_nxt == APB_ACCESS);
  end

  // State, watchdog and all registered outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= APB_IDLE;
      wd_cnt      <= '0;
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wd_cnt      <= wd_cnt_nxt;
      apb.PSEL    <= psel_nxt;
      apb.PENABLE <= penable_nxt;
      apb.PWRITE  <= pwrite_nxt;
      apb.PADDR   <= paddr_nxt;
      apb.PWDATA  <= pwdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master; the bench plays the APB responder and
// predicts response timing and contents from the transfer plan.
module tb_apb_master;
  import apb_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;

  int checks = 0;
  int errors = 0;

  apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb         (apb.master)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response prediction: latency counted from the accept edge to the cycle
  // in which rsp_valid is high.
  function automatic void model(input bit write, input int w, input bit slverr,
                                input logic [DW-1:0] rdata, output int lat,
                                output logic [DW-1:0] e_rdata, output bit e_err,
                                output bit e_to);
    if (TO != 0 && w >= int'(TO)) begin
      lat = 2 + int'(TO); e_rdata = '0; e_err = 1'b1; e_to = 1'b1;
    end else begin
      lat = 3 + w; e_rdata = write ? '0 : rdata; e_err = slverr; e_to = 1'b0;
    end
  endfunction

  task automatic junk_slave();
    apb.PREADY  = 1'($urandom);
    apb.PSLVERR = 1'($urandom);
    apb.PRDATA  = $urandom;
  endtask

  // One transfer: optional idle gap, command presented, then cycle-by-cycle
  // responder behaviour and checks until the response cycle.
  task automatic txn(input bit write, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input int w, input bit slverr, input logic [DW-1:0] rdata, input int gap);
    int            lat;
    logic [DW-1:0] e_rdata;
    bit            e_err, e_to;
    model(write, w, slverr, rdata, lat, e_rdata, e_err, e_to);
    for (int g = 0; g < gap; g++) begin
      cmd_valid = 1'b0;
      junk_slave();
      @(negedge PCLK);
      check("idle", 64'({rsp_valid, apb.PSEL, apb.PENABLE, cmd_ready}), 64'(4'b0001));
    end
    cmd_valid = 1'b1; cmd_write = write; cmd_addr = addr; cmd_wdata = wdata;
    check("ready", 64'(cmd_ready), 64'(1'b1));
    for (int c = 1; c <= lat; c++) begin
      @(negedge PCLK);
      if (c < lat) begin
        cmd_valid = 1'($urandom);
        cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
        if (c >= 2) begin
          apb.PREADY  = ((c - 2) == w);
          apb.PSLVERR = apb.PREADY ? slverr : 1'($urandom);
          apb.PRDATA  = apb.PREADY ? rdata : $urandom;
        end else junk_slave();
        check("busy", 64'({rsp_valid, apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, cmd_ready}),
              64'({1'b0, 1'b1, (c >= 2), write, addr, wdata, 1'b0}));
      end else begin
        cmd_valid = 1'b0;
        junk_slave();
        check("done_bus", 64'({rsp_valid, apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, cmd_ready}),
              64'({1'b1, 1'b0, 1'b0, write, addr, wdata, 1'b1}));
        check("rsp", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'({e_rdata, e_err, e_to}));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    int w, r;
    apb.PREADY = 1'b0; apb.PSLVERR = 1'b0; apb.PRDATA = '0;
    // Commands during reset are ignored.
    cmd_valid = 1'b1; cmd_addr = 8'h55; cmd_wdata = 32'h1;
    repeat (3) @(negedge PCLK);
    check("reset_vals", 64'({apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, rsp_valid, rsp_err, rsp_timeout}), 64'(0));
    check("reset_rdata", 64'(rsp_rdata), 64'(0));
    check("reset_ready", 64'(cmd_ready), 64'(1'b1));
    PRESETn = 1'b1; cmd_valid = 1'b0;

    txn(1'b1, 8'h04, 32'hDEADBEEF, 0, 1'b0, $urandom, 1);
    txn(1'b0, 8'h08, $urandom, 3, 1'b0, 32'h12345678, 0);
    txn(1'b0, 8'h0C, $urandom, 1, 1'b1, 32'hA5A5A5A5, 2);
    txn(1'b0, 8'h10, $urandom, 40, 1'b0, $urandom, 0);
    txn(1'b1, 8'h14, 32'h0BADF00D, 0, 1'b0, $urandom, 0);
    txn(1'b0, 8'h18, $urandom, 15, 1'b1, 32'hCAFEF00D, 1);
    txn(1'b1, 8'h1C, 32'h11112222, 16, 1'b0, $urandom, 0);
    for (int i = 0; i < 4; i++)
      txn(1'($urandom), AW'($urandom), $urandom, 0, 1'b0, $urandom, 0);

    for (int i = 0; i < 150; i++) begin
      r = int'($urandom % 10);
      if (r < 6)      w = int'($urandom % 3);
      else if (r < 8) w = int'($urandom_range(3, 8));
      else if (r < 9) w = int'($urandom_range(14, 16));
      else            w = 30;
      txn(1'($urandom), AW'($urandom), $urandom, w, 1'($urandom), $urandom, int'($urandom % 3));
    end

    // Reset pulse in the middle of an ACCESS phase.
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h3C; cmd_wdata = $urandom;
    apb.PREADY = 1'b0;
    @(negedge PCLK); cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("pre_reset_access", 64'({apb.PSEL, apb.PENABLE}), 64'(2'b11));
    #2 PRESETn = 1'b0;
    #1 check("async_reset", 64'({apb.PSEL, apb.PENABLE, apb.PADDR, rsp_valid}), 64'(0));
    cmd_valid = 1'b1;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1; cmd_valid = 1'b0; apb.PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("post_reset_idle", 64'({rsp_valid, apb.PSEL, apb.PENABLE, cmd_ready}), 64'(4'b0001));
    end
    txn(1'b1, 8'h40, 32'h600DCAFE, 2, 1'b0, $urandom, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
